// File: rtl/div_bit.sv
// ---------------------------------------------------------------------------
// div_bit : sequential unsigned restoring divider, 25-bit / 22-bit.
//
// It produces one quotient bit per clock. The fixed latency is 25 cycles
// from the accepting edge to the done pulse. Quotient bits shift into the
// dividend register as the dividend shifts out.
//
// Ports
//   m_clock       in   1   clock, rising edge
//   p_reset       in   1   synchronous active-high reset
//   div_bit1      in  25   dividend (sampled on accepting edge)
//   div_bit2      in  22   divisor  (sampled on accepting edge)
//   div_bit_exe   in   1   start request, accepted in IDLE or DONE
//   div_bit_busy  out  1   high while iterating
//   div_bit_done  out  1   one-cycle pulse when results update
//   div_bit_quot  out 25   quotient (registered, held)
//   div_bit_rem   out 22   remainder (registered, held)
//   div_bit_dbz   out  1   last completed operation had divisor == 0
// ---------------------------------------------------------------------------
module div_bit (
    input  logic        m_clock,
    input  logic        p_reset,
    input  logic [24:0] div_bit1,
    input  logic [21:0] div_bit2,
    input  logic        div_bit_exe,
    output logic        div_bit_busy,
    output logic        div_bit_done,
    output logic [24:0] div_bit_quot,
    output logic [21:0] div_bit_rem,
    output logic        div_bit_dbz
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [24:0] dvd_q,   dvd_d;    // dividend shifting out, quotient shifting in
    logic [21:0] dsr_q,   dsr_d;    // captured divisor
    // The partial remainder is always below the divisor, so its 23rd bit is
    // always zero. Only 22 bits are stored; the extra bit exists only in t.
    logic [21:0] prem_q,  prem_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [24:0] quot_q,  quot_d;
    logic [21:0] rem_q,   rem_d;
    logic        dbz_q,   dbz_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    logic [22:0] t;
    logic        ge;
    logic [21:0] prem_next;
    logic [24:0] quot_next;

    // Divide-by-zero override of the final quotient and remainder.
    function automatic logic [46:0] finalize(input logic [24:0] q,
                                             input logic [21:0] r,
                                             input logic        zero);
        if (zero)
            return {25'h1FFFFFF, 22'd0};
        else
            return {q, r};
    endfunction

    // One restoring iteration. Subtracting in 22 bits is exact whenever
    // t >= divisor, because the result is then below the divisor.
    always_comb begin
        t         = {prem_q, dvd_q[24]};
        ge        = (t >= {1'b0, dsr_q});
        prem_next = ge ? (t[21:0] - dsr_q) : t[21:0];
        quot_next = {dvd_q[23:0], ge};
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (div_bit_exe) begin
                    dvd_d   = div_bit1;
                    dsr_d   = div_bit2;
                    prem_d  = '0;
                    cnt_d   = 5'd24;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                prem_d = prem_next;
                dvd_d  = quot_next;
                if (cnt_q == 5'd0) begin
                    state_d         = DONE;
                    {quot_d, rem_d} = finalize(quot_next, prem_next, dsr_q == 22'd0);
                    dbz_d           = (dsr_q == 22'd0);
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign div_bit_busy = busy_q;
    assign div_bit_done = done_q;
    assign div_bit_quot = quot_q;
    assign div_bit_rem  = rem_q;
    assign div_bit_dbz  = dbz_q;

endmodule
